// File: rtl/alu_32bit.sv
// 32-bit registered ALU: four arithmetic functions over a ripple-carry adder with a
// pre-conditioned B operand, four bitwise logic functions, one-cycle registered result.

module alu_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        S0,
    input  logic        S1,
    input  logic        S2,
    input  logic        Ci,
    output logic [31:0] F,
    output logic        Co
);

    logic [1:0]  sel_lo;
    logic [31:0] b_sel;
    logic [32:0] carry;
    logic [31:0] sum;
    logic [31:0] logic_res;
    logic [31:0] f_d;
    logic        co_d;

    assign sel_lo = {S1, S0};

    // Per-bit B-input mux: 0, B, ~B or all ones.
    always_comb begin
        b_sel = '0;
        unique case (sel_lo)
            2'b00: b_sel = '0;
            2'b01: b_sel = b;
            2'b10: b_sel = ~b;
            2'b11: b_sel = '1;
            default: b_sel = '0;
        endcase
    end

    // Ripple-carry chain of 32 full-adder cells.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = Ci;
        for (int i = 0; i < 32; i++) begin
            sum[i]     = a[i] ^ b_sel[i] ^ carry[i];
            carry[i+1] = (a[i] & b_sel[i]) | (a[i] & carry[i]) | (b_sel[i] & carry[i]);
        end
    end

    always_comb begin
        logic_res = '0;
        unique case (sel_lo)
            2'b00: logic_res = a | b;
            2'b01: logic_res = a ^ b;
            2'b10: logic_res = a & b;
            2'b11: logic_res = ~a;
            default: logic_res = '0;
        endcase
    end

    // Logic functions never report a carry.
    always_comb begin
        f_d  = sum;
        co_d = carry[32];
        if (S2) begin
            f_d  = logic_res;
            co_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F  <= '0;
            Co <= 1'b0;
        end else begin
            F  <= f_d;
            Co <= co_d;
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// Bench for alu_32bit: directed cases from the function table plus randomized operations
// checked against an arithmetic reference model.

module tb_alu_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        S0;
    logic        S1;
    logic        S2;
    logic        Ci;
    logic [31:0] F;
    logic        Co;

    int checks;
    int failures;

    alu_32bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .S0   (S0),
        .S1   (S1),
        .S2   (S2),
        .Ci   (Ci),
        .F    (F),
        .Co   (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {Co, F} computed with plain 33-bit arithmetic and bitwise operators.
    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [2:0] s, input logic ci);
        logic [32:0] r;
        case (s)
            3'b000: r = {1'b0, ma} + 33'(ci);
            3'b001: r = {1'b0, ma} + {1'b0, mb} + 33'(ci);
            3'b010: r = {1'b0, ma} + {1'b0, ~mb} + 33'(ci);
            3'b011: r = {1'b0, ma} + 33'h0FFFFFFFF + 33'(ci);
            3'b100: r = {1'b0, ma | mb};
            3'b101: r = {1'b0, ma ^ mb};
            3'b110: r = {1'b0, ma & mb};
            default: r = {1'b0, ~ma};
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic [2:0] s,
                         input logic ci);
        a  = da;
        b  = db;
        S2 = s[2];
        S1 = s[1];
        S0 = s[0];
        Ci = ci;
    endtask

    task automatic check(input string tag, input logic [32:0] expected);
        checks++;
        assert ({Co, F} === expected)
        else begin
            failures++;
            $error("FAIL %s: got Co=%b F=%h, expected Co=%b F=%h",
                   tag, Co, F, expected[32], expected[31:0]);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic op(input string tag, input logic [31:0] da, input logic [31:0] db,
                      input logic [2:0] s, input logic ci, input logic [32:0] expected);
        drive(da, db, s, ci);
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rs;
        logic        rc;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(32'hDEADBEEF, 32'h12345678, 3'b001, 1'b1);
        @(posedge clk);
        #1;
        check("reset", 33'h0);
        rst_n = 1'b1;

        op("and1",   32'h01010101, 32'h61616161, 3'b110, 1'b0, {1'b0, 32'h01010101});
        op("and2",   32'h0101010F, 32'h61216061, 3'b110, 1'b0, {1'b0, 32'h01010001});
        op("and3",   32'hA5010107, 32'h61016567, 3'b110, 1'b1, {1'b0, 32'h21010107});
        op("addwrap", 32'hFFFFFFFF, 32'h1, 3'b001, 1'b0, {1'b1, 32'h0});
        op("addc",   32'd5, 32'd3, 3'b001, 1'b1, {1'b0, 32'd9});
        op("sub",    32'd5, 32'd3, 3'b010, 1'b1, {1'b1, 32'd2});
        op("subneg", 32'd3, 32'd5, 3'b010, 1'b1, {1'b0, 32'hFFFFFFFE});
        op("subm1",  32'd5, 32'd3, 3'b010, 1'b0, {1'b1, 32'd1});
        op("or",     32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b1, {1'b0, 32'hFFF0FFF0});
        op("xor",    32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 1'b1, {1'b0, 32'h0FF00FF0});
        op("not",    32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 1'b1, {1'b0, 32'h0F0F0F0F});
        op("dec0",   32'h0, 32'h0, 3'b011, 1'b0, {1'b0, 32'hFFFFFFFF});
        op("dec",    32'd10, 32'h0, 3'b011, 1'b0, {1'b1, 32'd9});
        op("xferA",  32'h89ABCDEF, 32'h0, 3'b011, 1'b1, {1'b1, 32'h89ABCDEF});
        op("inc",    32'hFFFFFFFF, 32'h5, 3'b000, 1'b1, {1'b1, 32'h0});
        op("xfer",   32'h13572468, 32'h5, 3'b000, 1'b0, {1'b0, 32'h13572468});

        // Reset overrides a carry-producing add; the live result returns afterwards.
        op("prerst", 32'hFFFFFFFF, 32'h2, 3'b001, 1'b0, {1'b1, 32'h1});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid", 33'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst", {1'b1, 32'h1});

        // Input change between edges only matters at the next edge.
        drive(32'd7, 32'd8, 3'b001, 1'b0);
        #2;
        check("hold", {1'b1, 32'h1});
        @(posedge clk);
        #1;
        check("update", {1'b0, 32'd15});

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 3'($urandom_range(0, 7));
            rc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = 32'hFFFFFFFF;
            if (i % 10 == 1) rb = ra;
            op("rand", ra, rb, rs, rc, model(ra, rb, rs, rc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
